oled_pwr_seq: RTL and testbench

Power-up, command-streaming and power-down sequencer for the PmodOLEDrgb display, sitting between the processor-side slot logic and the 8-bit SPI byte engine. It owns the display's PMODEN, VCCEN, RES, DC and CS lines and walks the mandated power-on sequence without software timing. The sequence is: rail enable, reset pulse, an init command list read from an external ROM, VCC enable, then display-on. After init it forwards single runtime bytes from the host and runs the reverse sequence on request.

---
 rtl/oled_pwr_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_oled_pwr_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/oled_pwr_seq.sv
// Power-up / command-streaming / power-down sequencer for the PmodOLEDrgb.
// Owns the display rail, reset, VCC, DC and CS pins. It walks the power-on
// sequence, streams the init list from a synchronous ROM, forwards host
// bytes while READY, and runs the reverse sequence on request.
module oled_pwr_seq #(
  parameter int PWR_CYC = 2_000_000,
  parameter int RES_CYC = 300,
  parameter int VCC_CYC = 2_500_000,
  parameter int N_INIT  = 38,
  parameter int AW      = (N_INIT > 1) ? $clog2(N_INIT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          init_done,
  input  logic          tx_valid,
  input  logic [7:0]    tx_data,
  input  logic          tx_dc,
  output logic          tx_ready,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic          spi_start,
  output logic [7:0]    spi_din,
  input  logic          spi_ready,
  output logic          oled_dc,
  output logic          oled_cs_n,
  output logic          oled_res_n,
  output logic          oled_vccen,
  output logic          oled_pmoden
);

  typedef enum logic [3:0] {
    S_OFF, S_PWR_WAIT, S_RES_LO, S_RES_HI, S_FETCH, S_B_SETUP, S_B_START,
    S_B_WAIT, S_VCC_WAIT, S_ON_CMD, S_READY, S_OFF_CMD, S_OFF_WAIT
  } state_t;

  // Where the shared byte sub-sequence hands control back to.
  typedef enum logic [1:0] {
    RET_INIT, RET_ON, RET_HOST, RET_OFF
  } ret_t;

  // A wait of N cycles loads N-1 and exits when the counter reads zero.
  localparam logic [31:0]   PWR_LD   = 32'(PWR_CYC - 1);
  localparam logic [31:0]   RES_LD   = 32'(RES_CYC - 1);
  localparam logic [31:0]   VCC_LD   = 32'(VCC_CYC - 1);
  // FETCH spends one cycle presenting the address and one with data valid.
  localparam logic [31:0]   FETCH_LD = 32'd1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_INIT - 1);
  localparam logic [7:0]    CMD_ON   = 8'hAF;
  localparam logic [7:0]    CMD_OFF  = 8'hAE;

  state_t        state_q, state_d;
  ret_t          ret_q, ret_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]    din_q, din_d;
  logic          spi_start_q, spi_start_d;
  logic          dc_q, dc_d;
  logic          cs_n_q, cs_n_d;
  logic          res_n_q, res_n_d;
  logic          vccen_q, vccen_d;
  logic          pmoden_q, pmoden_d;
  logic          busy_q, busy_d;
  logic          init_done_q, init_done_d;

  // Next-state and registered-output logic for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rom_addr_d  = rom_addr_q;
    din_d       = din_q;
    spi_start_d = 1'b0;
    dc_d        = dc_q;
    cs_n_d      = cs_n_q;
    res_n_d     = res_n_q;
    vccen_d     = vccen_q;
    pmoden_d    = pmoden_q;

    case (state_q)
      S_OFF: begin
        if (start) begin
          state_d  = S_PWR_WAIT;
          pmoden_d = 1'b1;
          cnt_d    = PWR_LD;
        end
      end
      S_PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RES_LO;
          res_n_d = 1'b0;
          cnt_d   = RES_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_RES_LO: begin
        if (cnt_q == '0) begin
          state_d = S_RES_HI;
          res_n_d = 1'b1;
          cnt_d   = RES_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_RES_HI: begin
        if (cnt_q == '0) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          rom_addr_d = '0;
          cnt_d      = FETCH_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_FETCH: begin
        if (cnt_q == '0) begin
          state_d = S_B_SETUP;
          din_d   = rom_data;
          dc_d    = 1'b0;
          cs_n_d  = 1'b0;
          ret_d   = RET_INIT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_B_SETUP: begin
        state_d = S_B_START;
      end
      S_B_START: begin
        if (spi_ready) begin
          state_d     = S_B_WAIT;
          spi_start_d = 1'b1;
        end
      end
      S_B_WAIT: begin
        // spi_start_q marks the first cycle, where the engine may still
        // report idle because it has not yet seen the pulse.
        if (!spi_start_q && spi_ready) begin
          cs_n_d = 1'b1;
          case (ret_q)
            RET_INIT: begin
              if (idx_q == LAST_IDX) begin
                state_d = S_VCC_WAIT;
                vccen_d = 1'b1;
                cnt_d   = VCC_LD;
              end else begin
                state_d    = S_FETCH;
                idx_d      = idx_q + AW'(1);
                rom_addr_d = idx_q + AW'(1);
                cnt_d      = FETCH_LD;
              end
            end
            RET_ON, RET_HOST: begin
              state_d = S_READY;
            end
            default: begin
              state_d = S_OFF_WAIT;
              vccen_d = 1'b0;
              cnt_d   = VCC_LD;
            end
          endcase
        end
      end
      S_VCC_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ON_CMD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_ON_CMD: begin
        state_d = S_B_SETUP;
        din_d   = CMD_ON;
        dc_d    = 1'b0;
        cs_n_d  = 1'b0;
        ret_d   = RET_ON;
      end
      S_READY: begin
        // stop has priority: a host byte offered in the same cycle is dropped.
        if (stop) begin
          state_d = S_OFF_CMD;
        end else if (tx_valid) begin
          state_d = S_B_SETUP;
          din_d   = tx_data;
          dc_d    = tx_dc;
          cs_n_d  = 1'b0;
          ret_d   = RET_HOST;
        end
      end
      S_OFF_CMD: begin
        state_d = S_B_SETUP;
        din_d   = CMD_OFF;
        dc_d    = 1'b0;
        cs_n_d  = 1'b0;
        ret_d   = RET_OFF;
      end
      S_OFF_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_OFF;
          pmoden_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    busy_d      = (state_d != S_OFF) && (state_d != S_READY);
    init_done_d = (state_d == S_READY);
  end

  // State and output registers; reset abandons any byte in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OFF;
      ret_q       <= RET_INIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      rom_addr_q  <= '0;
      din_q       <= '0;
      spi_start_q <= 1'b0;
      dc_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      res_n_q     <= 1'b1;
      vccen_q     <= 1'b0;
      pmoden_q    <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rom_addr_q  <= rom_addr_d;
      din_q       <= din_d;
      spi_start_q <= spi_start_d;
      dc_q        <= dc_d;
      cs_n_q      <= cs_n_d;
      res_n_q     <= res_n_d;
      vccen_q     <= vccen_d;
      pmoden_q    <= pmoden_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign tx_ready    = (state_q == S_READY) & ~stop;
  assign busy        = busy_q;
  assign init_done   = init_done_q;
  assign rom_addr    = rom_addr_q;
  assign spi_start   = spi_start_q;
  assign spi_din     = din_q;
  assign oled_dc     = dc_q;
  assign oled_cs_n   = cs_n_q;
  assign oled_res_n  = res_n_q;
  assign oled_vccen  = vccen_q;
  assign oled_pmoden = pmoden_q;

endmodule

// File: tb/tb_oled_pwr_seq.sv
// Directed bench for oled_pwr_seq with a small synchronous ROM and a
// byte-engine model that stays busy for 16 cycles after each spi_start.
module tb_oled_pwr_seq;

  logic       clk = 1'b0;
  logic       reset, start, stop, tx_valid, tx_dc;
  logic [7:0] tx_data;
  logic       busy, init_done, tx_ready, spi_start;
  logic [1:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] spi_din;
  logic       spi_ready = 1'b1;
  logic       oled_dc, oled_cs_n, oled_res_n, oled_vccen, oled_pmoden;

  logic [7:0] rom [0:3] = '{8'hFD, 8'h12, 8'hAE, 8'hA0};
  int         scnt = 0;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n = 0;
  logic [7:0] log_din [0:15];
  logic       log_dc  [0:15];
  int         log_cyc [0:15];
  int         vcc_rise_cyc = 0;
  logic       vcc_prev = 1'b0;
  int         i;
  int         bad;

  oled_pwr_seq #(
    .PWR_CYC(10), .RES_CYC(3), .VCC_CYC(20), .N_INIT(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .busy(busy), .init_done(init_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_dc(tx_dc), .tx_ready(tx_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .spi_start(spi_start), .spi_din(spi_din), .spi_ready(spi_ready),
    .oled_dc(oled_dc), .oled_cs_n(oled_cs_n), .oled_res_n(oled_res_n),
    .oled_vccen(oled_vccen), .oled_pmoden(oled_pmoden)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous init ROM.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Byte engine: ready drops the cycle after spi_start, returns 16 cycles later.
  always @(posedge clk) begin
    if (reset) begin
      spi_ready <= 1'b1;
      scnt      <= 0;
    end else if (spi_start) begin
      spi_ready <= 1'b0;
      scnt      <= 15;
    end else if (!spi_ready) begin
      if (scnt == 0) spi_ready <= 1'b1;
      else           scnt <= scnt - 1;
    end
  end

  // Log every byte launched and the cycle VCC came up.
  always @(negedge clk) begin
    if (spi_start && n < 16) begin
      log_din[n] = spi_din;
      log_dc[n]  = oled_dc;
      log_cyc[n] = cyc;
      n++;
    end
    if (oled_vccen && !vcc_prev) vcc_rise_cyc = cyc;
    vcc_prev = oled_vccen;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; stop = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; tx_dc = 1'b0;

    // Reset with start held high.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_spi_start", spi_start, 1'b0);
    chk("rst_spi_din", spi_din, 8'h00);
    chk("rst_rom_addr", rom_addr, 2'd0);
    chk("rst_dc", oled_dc, 1'b0);
    chk("rst_cs_n", oled_cs_n, 1'b1);
    chk("rst_res_n", oled_res_n, 1'b1);
    chk("rst_vccen", oled_vccen, 1'b0);
    chk("rst_pmoden", oled_pmoden, 1'b0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_reset_ignored", oled_pmoden, 1'b0);

    // Power-up; stop in PWR_WAIT and tx_valid during init must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pmoden_after_start", oled_pmoden, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    stop = 1'b1; tx_valid = 1'b1; tx_data = 8'h77; tx_dc = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (8) @(negedge clk);
    chk("res_n_before_low", oled_res_n, 1'b1);
    @(negedge clk);
    chk("res_n_low_first", oled_res_n, 1'b0);
    repeat (2) @(negedge clk);
    chk("res_n_low_third", oled_res_n, 1'b0);
    @(negedge clk);
    chk("res_n_high_again", oled_res_n, 1'b1);

    i = 0;
    while (!init_done && i < 400) begin
      if (oled_vccen) tx_valid = 1'b0;
      @(negedge clk);
      i++;
    end
    tx_valid = 1'b0;
    chk("init_done_reached", init_done, 1'b1);
    chk("init_byte_count", n, 5);
    chk("init_b0", log_din[0], 8'hFD);
    chk("init_b1", log_din[1], 8'h12);
    chk("init_b2", log_din[2], 8'hAE);
    chk("init_b3", log_din[3], 8'hA0);
    chk("init_b4_on", log_din[4], 8'hAF);
    chk("init_dc_all_cmd", {log_dc[0], log_dc[1], log_dc[2], log_dc[3], log_dc[4]}, 5'b0);
    chk("vcc_lead_ge_20", (log_cyc[4] - vcc_rise_cyc) >= 20, 1'b1);
    chk("ready_busy", busy, 1'b0);
    chk("ready_tx_ready", tx_ready, 1'b1);
    chk("ready_cs_n", oled_cs_n, 1'b1);

    // Runtime data byte.
    tx_valid = 1'b1; tx_data = 8'h5A; tx_dc = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("host_tx_ready_low", tx_ready, 1'b0);
    chk("host_cs_low", oled_cs_n, 1'b0);
    chk("host_dc_high", oled_dc, 1'b1);
    i = 0; bad = 0;
    while (!init_done && i < 60) begin
      if (!oled_cs_n && !oled_dc) bad++;
      if (tx_ready) bad++;
      @(negedge clk);
      i++;
    end
    chk("host_done", init_done, 1'b1);
    chk("host_window_violations", bad, 0);
    chk("host_tx_ready_back", tx_ready, 1'b1);
    chk("host_cs_released", oled_cs_n, 1'b1);
    chk("host_byte_count", n, 6);
    chk("host_byte", log_din[5], 8'h5A);
    chk("host_byte_dc", log_dc[5], 1'b1);

    // start in READY is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_in_ready_busy", busy, 1'b0);
    chk("start_in_ready_done", init_done, 1'b1);
    chk("start_in_ready_count", n, 6);

    // Power-down with a simultaneous host byte that must be dropped.
    stop = 1'b1; tx_valid = 1'b1; tx_data = 8'h33; tx_dc = 1'b1;
    #1;
    chk("stop_masks_tx_ready", tx_ready, 1'b0);
    @(negedge clk);
    stop = 1'b0; tx_valid = 1'b0;
    chk("off_busy", busy, 1'b1);
    chk("off_init_done", init_done, 1'b0);
    i = 0;
    while (oled_vccen && i < 80) begin
      @(negedge clk);
      i++;
    end
    chk("vccen_dropped", oled_vccen, 1'b0);
    chk("off_byte_count", n, 7);
    chk("off_byte", log_din[6], 8'hAE);
    chk("off_byte_dc", log_dc[6], 1'b0);
    repeat (19) @(negedge clk);
    chk("pmoden_hold_19", oled_pmoden, 1'b1);
    @(negedge clk);
    chk("pmoden_off_20", oled_pmoden, 1'b0);
    chk("off_idle_busy", busy, 1'b0);
    chk("off_no_extra_byte", n, 7);

    // Reset while the second init byte is in flight.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (n < 9 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("restart_byte_count", n, 9);
    chk("restart_b1", log_din[8], 8'h12);
    @(negedge clk);
    chk("inflight_cs_low", oled_cs_n, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", oled_cs_n, 1'b1);
    chk("midrst_pmoden", oled_pmoden, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_spi_din", spi_din, 8'h00);
    chk("midrst_rom_addr", rom_addr, 2'd0);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (n < 10 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("after_rst_count", n, 10);
    chk("after_rst_first_byte", log_din[9], 8'hFD);
    chk("after_rst_first_dc", log_dc[9], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
